// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared constants and types for the RV32I operand-fetch slice.
//   XLEN     : data width
//   NREG     : number of architectural registers
//   AW       : register address width
//   REG_ZERO : index of the hard-wired zero register x0
//   dec_op_t : decoded-operand fields presented by the decoder
//   fetch_out_t : contents of the operand-fetch output register
//   sel_operand : operand source selection (x0 / writeback bypass / reg_file)
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    localparam logic [AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic [AW-1:0] rd;
        logic          use_rs1;
        logic          use_rs2;
        logic          rd_wr;
    } dec_op_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [AW-1:0]   rd;
        logic            rd_wr;
    } fetch_out_t;

    // x0 always reads as zero, even if the writeback bus targets it; otherwise
    // a same-cycle writeback to the source wins over the stale reg_file value.
    function automatic logic [XLEN-1:0] sel_operand(
        input logic [AW-1:0]   idx,
        input logic [XLEN-1:0] rg_data,
        input logic            wb_en,
        input logic [AW-1:0]   wb_addr,
        input logic [XLEN-1:0] wb_data
    );
        if (idx == REG_ZERO) begin
            return '0;
        end else if (wb_en && (wb_addr == idx)) begin
            return wb_data;
        end
        return rg_data;
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// -----------------------------------------------------------------------------
// operand_fetch_if
// Bundles every non-clock/reset signal of operand_fetch.
//   in_*        : decoded instruction and its valid/ready handshake
//   rg_sr*      : reg_file read ports (address out, combinational data in)
//   wb_*        : writeback bus snooped for bypass and scoreboard clear
//   flush       : drop the held instruction
//   sb_clr      : clear all scoreboard busy bits
//   out_*       : captured operands and valid/ready handshake toward execute
// Modports: slave = operand_fetch, master = the surrounding pipeline.
// -----------------------------------------------------------------------------
interface operand_fetch_if;
    import riscv_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [AW-1:0]   in_rs1;
    logic [AW-1:0]   in_rs2;
    logic            in_use_rs1;
    logic            in_use_rs2;
    logic [AW-1:0]   in_rd;
    logic            in_rd_wr;
    logic [AW-1:0]   rg_sr1_addr;
    logic [AW-1:0]   rg_sr2_addr;
    logic [XLEN-1:0] rg_sr1_data;
    logic [XLEN-1:0] rg_sr2_data;
    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            flush;
    logic            sb_clr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_op1;
    logic [XLEN-1:0] out_op2;
    logic [AW-1:0]   out_rd;
    logic            out_rd_wr;

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_rd, in_rd_wr,
        input  rg_sr1_data, rg_sr2_data, wb_en, wb_addr, wb_data,
        input  flush, sb_clr, out_ready,
        output in_ready, rg_sr1_addr, rg_sr2_addr,
        output out_valid, out_op1, out_op2, out_rd, out_rd_wr
    );

    modport master (
        output in_valid, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_rd, in_rd_wr,
        output rg_sr1_data, rg_sr2_data, wb_en, wb_addr, wb_data,
        output flush, sb_clr, out_ready,
        input  in_ready, rg_sr1_addr, rg_sr2_addr,
        input  out_valid, out_op1, out_op2, out_rd, out_rd_wr
    );

endinterface

// File: rtl/operand_fetch_scoreboard.sv
// -----------------------------------------------------------------------------
// operand_fetch_scoreboard
// Busy-bit vector of in-flight destination registers.
//   clk, rst            : clock, synchronous active-high reset
//   set_en, set_idx     : mark a register busy (instruction left for execute)
//   clr_en, clr_idx     : mark a register free (writeback)
//   clr_all             : clear every bit, overriding a same-cycle set
//   q_raw1/2_idx        : source queries; answer ignores a bit being cleared
//                         by writeback this cycle (bypass covers that case)
//   q_waw_idx           : destination query; raw busy bit
// -----------------------------------------------------------------------------
module operand_fetch_scoreboard
    import riscv_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          set_en,
    input  logic [AW-1:0] set_idx,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_idx,
    input  logic          clr_all,
    input  logic [AW-1:0] q_raw1_idx,
    input  logic [AW-1:0] q_raw2_idx,
    input  logic [AW-1:0] q_waw_idx,
    output logic          raw1_busy_o,
    output logic          raw2_busy_o,
    output logic          waw_busy_o
);

    logic [NREG-1:0] busy_q, busy_d;

    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_idx] = 1'b0;
        // Applied after the clear so a set to the same index wins.
        if (set_en) busy_d[set_idx] = 1'b1;
        if (clr_all) busy_d = '0;
        busy_d[REG_ZERO] = 1'b0;
    end

    // NOTE: the busy vector is plain flops, not a RAM, so it is reset as a
    // whole; a stale bit after reset would stall forever.
    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign raw1_busy_o = busy_q[q_raw1_idx] & ~(clr_en & (clr_idx == q_raw1_idx));
    assign raw2_busy_o = busy_q[q_raw2_idx] & ~(clr_en & (clr_idx == q_raw2_idx));
    assign waw_busy_o  = busy_q[q_waw_idx];

endmodule

// File: rtl/operand_fetch.sv
// -----------------------------------------------------------------------------
// operand_fetch
// One pipeline stage between decode and execute: drives reg_file read
// addresses, captures operands (with same-cycle writeback bypass), and stalls
// on RAW/WAW hazards tracked by a busy-bit scoreboard.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : operand_fetch_if.slave (instruction in, reg_file read, writeback
//          snoop, flush/sb_clr, operands out)
// -----------------------------------------------------------------------------
module operand_fetch
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    operand_fetch_if.slave  bus
);

    dec_op_t    dec;
    fetch_out_t out_q, out_d;
    logic       acc, fire;
    logic       raw1, raw2, waw;
    logic       sb_raw1, sb_raw2, sb_waw;

    assign dec = '{rs1:     bus.in_rs1,     rs2:     bus.in_rs2,
                   rd:      bus.in_rd,      use_rs1: bus.in_use_rs1,
                   use_rs2: bus.in_use_rs2, rd_wr:   bus.in_rd_wr};

    assign bus.rg_sr1_addr = dec.rs1;
    assign bus.rg_sr2_addr = dec.rs2;

    // A flushed occupant never reaches execute, so it must not mark its rd busy.
    assign fire = out_q.valid & bus.out_ready & ~bus.flush;

    operand_fetch_scoreboard u_sb (
        .clk         (clk),
        .rst         (rst),
        .set_en      (fire & out_q.rd_wr),
        .set_idx     (out_q.rd),
        .clr_en      (bus.wb_en),
        .clr_idx     (bus.wb_addr),
        .clr_all     (bus.sb_clr),
        .q_raw1_idx  (dec.rs1),
        .q_raw2_idx  (dec.rs2),
        .q_waw_idx   (dec.rd),
        .raw1_busy_o (sb_raw1),
        .raw2_busy_o (sb_raw2),
        .waw_busy_o  (sb_waw)
    );

    // The current occupant is not yet in the scoreboard (it is set on fire),
    // so its destination is checked directly.
    function automatic logic occ_writes(input logic [AW-1:0] idx);
        return out_q.valid & out_q.rd_wr & (out_q.rd == idx);
    endfunction

    assign raw1 = dec.use_rs1 & (dec.rs1 != REG_ZERO) & (sb_raw1 | occ_writes(dec.rs1));
    assign raw2 = dec.use_rs2 & (dec.rs2 != REG_ZERO) & (sb_raw2 | occ_writes(dec.rs2));
    assign waw  = dec.rd_wr   & (dec.rd  != REG_ZERO) & (sb_waw  | occ_writes(dec.rd));

    assign bus.in_ready = ~rst & ~bus.flush & ~raw1 & ~raw2 & ~waw
                        & (~out_q.valid | bus.out_ready);
    assign acc = bus.in_valid & bus.in_ready;

    always_comb begin
        out_d = out_q;
        if (bus.flush) begin
            out_d.valid = 1'b0;
        end else if (acc) begin
            out_d.valid = 1'b1;
            out_d.op1   = sel_operand(dec.rs1, bus.rg_sr1_data, bus.wb_en, bus.wb_addr, bus.wb_data);
            out_d.op2   = sel_operand(dec.rs2, bus.rg_sr2_data, bus.wb_en, bus.wb_addr, bus.wb_data);
            out_d.rd    = dec.rd;
            out_d.rd_wr = dec.rd_wr;
        end else if (fire) begin
            out_d.valid = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) out_q <= '0;
        else     out_q <= out_d;
    end

    assign bus.out_valid = out_q.valid;
    assign bus.out_op1   = out_q.op1;
    assign bus.out_op2   = out_q.op2;
    assign bus.out_rd    = out_q.rd;
    assign bus.out_rd_wr = out_q.rd_wr;

endmodule

// File: tb/tb_operand_fetch.sv
// -----------------------------------------------------------------------------
// tb_operand_fetch
// Directed scenarios followed by randomized traffic, every cycle compared
// against a reference model of the stage (busy set, one held instruction,
// and a simple array standing in for reg_file).
// -----------------------------------------------------------------------------
module tb_operand_fetch;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    operand_fetch_if bus ();

    operand_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // reg_file stand-in: combinational read; x0 is stored naively so the
    // stage's own zeroing of x0 is exercised.
    logic [XLEN-1:0] regs [NREG];
    assign bus.rg_sr1_data = regs[bus.rg_sr1_addr];
    assign bus.rg_sr2_data = regs[bus.rg_sr2_addr];

    // Reference model state
    logic [NREG-1:0] m_busy;
    logic            m_valid;
    logic [XLEN-1:0] m_op1, m_op2;
    logic [AW-1:0]   m_rd;
    logic            m_rd_wr;

    int   n_pass  = 0;
    int   n_total = 0;
    logic last_ready;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] idx);
        if (idx == 0) return '0;
        if (bus.wb_en && bus.wb_addr == idx) return bus.wb_data;
        return regs[idx];
    endfunction

    // Source blocked if it is in flight (and not being written back right now)
    // or it is the held instruction's destination.
    function automatic logic m_src_blocked(input logic used, input logic [AW-1:0] idx);
        if (!used || idx == 0) return 1'b0;
        if (m_busy[idx] && !(bus.wb_en && bus.wb_addr == idx)) return 1'b1;
        return m_valid && m_rd_wr && m_rd == idx;
    endfunction

    function automatic logic m_dst_blocked(input logic wr, input logic [AW-1:0] idx);
        if (!wr || idx == 0) return 1'b0;
        return m_busy[idx] || (m_valid && m_rd_wr && m_rd == idx);
    endfunction

    task automatic idle();
        bus.in_valid = 0; bus.in_rs1 = 0; bus.in_rs2 = 0;
        bus.in_use_rs1 = 0; bus.in_use_rs2 = 0; bus.in_rd = 0; bus.in_rd_wr = 0;
        bus.wb_en = 0; bus.wb_addr = 0; bus.wb_data = 0;
        bus.flush = 0; bus.sb_clr = 0; bus.out_ready = 1;
    endtask

    task automatic set_instr(input logic v, input int rs1, input int rs2, input logic u1,
                             input logic u2, input int rd, input logic wr);
        bus.in_valid = v; bus.in_rs1 = AW'(rs1); bus.in_rs2 = AW'(rs2);
        bus.in_use_rs1 = u1; bus.in_use_rs2 = u2; bus.in_rd = AW'(rd); bus.in_rd_wr = wr;
    endtask

    task automatic set_wb(input logic en, input int addr, input logic [XLEN-1:0] data);
        bus.wb_en = en; bus.wb_addr = AW'(addr); bus.wb_data = data;
    endtask

    // Entered 1 time unit after a rising edge with inputs already driven.
    // Compares the DUT before the next edge, then advances the model across it.
    task automatic step();
        logic            exp_ready, acc, fire;
        logic [NREG-1:0] nb;
        #3;
        exp_ready = !rst && !bus.flush
                 && !m_src_blocked(bus.in_use_rs1, bus.in_rs1)
                 && !m_src_blocked(bus.in_use_rs2, bus.in_rs2)
                 && !m_dst_blocked(bus.in_rd_wr, bus.in_rd)
                 && (!m_valid || bus.out_ready);
        check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
        check("sr1_addr", 32'(bus.rg_sr1_addr), 32'(bus.in_rs1));
        check("sr2_addr", 32'(bus.rg_sr2_addr), 32'(bus.in_rs2));
        check("out_valid", 32'(bus.out_valid), 32'(m_valid));
        if (m_valid) begin
            check("out_op1", bus.out_op1, m_op1);
            check("out_op2", bus.out_op2, m_op2);
            check("out_rd", 32'(bus.out_rd), 32'(m_rd));
            check("out_rd_wr", 32'(bus.out_rd_wr), 32'(m_rd_wr));
        end
        last_ready = bus.in_ready;

        acc  = bus.in_valid && exp_ready;
        fire = m_valid && bus.out_ready && !bus.flush;
        nb = m_busy;
        if (bus.wb_en && bus.wb_addr != 0) nb[bus.wb_addr] = 1'b0;
        if (fire && m_rd_wr && m_rd != 0) nb[m_rd] = 1'b1;
        if (bus.sb_clr) nb = '0;

        @(posedge clk);
        #1;
        if (rst) begin
            m_busy = '0; m_valid = 0; m_op1 = 0; m_op2 = 0; m_rd = 0; m_rd_wr = 0;
        end else begin
            if (acc) begin
                m_op1   = m_read(bus.in_rs1);
                m_op2   = m_read(bus.in_rs2);
                m_rd    = bus.in_rd;
                m_rd_wr = bus.in_rd_wr;
            end
            m_busy  = nb;
            m_valid = bus.flush ? 1'b0 : (acc ? 1'b1 : (fire ? 1'b0 : m_valid));
        end
        if (bus.wb_en) regs[bus.wb_addr] = bus.wb_data;
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) regs[i] = '0;
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        m_busy = '0; m_valid = 0; m_op1 = 0; m_op2 = 0; m_rd = 0; m_rd_wr = 0;

        // Reset then idle
        step();
        check("rst_ready", 32'(last_ready), 0);
        rst = 0;
        step();
        check("idle_ready", 32'(last_ready), 1);
        check("idle_valid", 32'(bus.out_valid), 0);
        check("idle_op1", bus.out_op1, 0);
        check("idle_rd_wr", 32'(bus.out_rd_wr), 0);

        // x1 = DEADBEEF, then read x1/x2
        set_wb(1, 1, 32'hDEADBEEF); step(); set_wb(0, 0, 0);
        set_instr(1, 1, 2, 1, 1, 0, 0); step(); idle();
        check("x1_op1", bus.out_op1, 32'hDEADBEEF);
        check("x2_op2", bus.out_op2, 32'h0);
        step();

        // RAW stall on x5 until its writeback, then bypass
        set_instr(1, 0, 0, 0, 0, 5, 1); step(); idle(); step();
        set_instr(1, 5, 0, 1, 0, 0, 0); step();
        check("raw_stall1", 32'(last_ready), 0);
        step();
        check("raw_stall2", 32'(last_ready), 0);
        set_wb(1, 5, 32'h12345678); step();
        check("raw_bypass_ready", 32'(last_ready), 1);
        idle();
        check("raw_bypass_op1", bus.out_op1, 32'h12345678);
        step();

        // x0 source with writeback to x0
        set_instr(1, 0, 0, 1, 1, 0, 0); set_wb(1, 0, 32'hFFFFFFFF); step(); idle();
        check("x0_op1", bus.out_op1, 32'h0);
        check("x0_op2", bus.out_op2, 32'h0);
        step();

        // Backpressure: hold rd=9 for 3 cycles
        set_instr(1, 1, 0, 1, 0, 9, 1); step();
        bus.out_ready = 0;
        set_instr(1, 1, 0, 1, 0, 10, 1);
        repeat (3) begin
            step();
            check("hold_ready", 32'(last_ready), 0);
            check("hold_rd", 32'(bus.out_rd), 9);
            check("hold_op1", bus.out_op1, 32'hDEADBEEF);
        end
        bus.out_ready = 1; step();
        check("release_ready", 32'(last_ready), 1);
        idle(); step();
        set_instr(1, 0, 0, 0, 0, 9, 1); step();
        check("waw9_blocked", 32'(last_ready), 0);
        set_wb(1, 9, 32'h99); step(); set_wb(0, 0, 0);
        step();
        check("waw9_free", 32'(last_ready), 1);
        idle(); step();

        // Flush drops the occupant without marking rd busy
        set_instr(1, 0, 0, 0, 0, 7, 1); step();
        set_instr(1, 0, 0, 0, 0, 11, 1); bus.flush = 1; step();
        check("flush_ready", 32'(last_ready), 0);
        idle();
        check("flush_valid", 32'(bus.out_valid), 0);
        set_instr(1, 0, 0, 0, 0, 7, 1); step();
        check("flush_rd7_free", 32'(last_ready), 1);
        idle(); step();

        // sb_clr overrides a same-cycle set
        set_instr(1, 0, 0, 0, 0, 3, 1); step();
        idle(); bus.sb_clr = 1; step(); bus.sb_clr = 0;
        set_instr(1, 0, 0, 0, 0, 3, 1); step();
        check("sbclr_rd3_free", 32'(last_ready), 1);
        idle(); step();
        bus.sb_clr = 1; step(); bus.sb_clr = 0;

        // Randomized traffic over a small register window to provoke hazards
        for (int c = 0; c < 600; c++) begin
            rst            = ($urandom_range(0, 99) == 0);
            bus.flush      = ($urandom_range(0, 24) == 0);
            bus.sb_clr     = ($urandom_range(0, 39) == 0);
            bus.out_ready  = ($urandom_range(0, 3) != 0);
            bus.in_valid   = ($urandom_range(0, 2) != 0);
            bus.in_rs1     = AW'($urandom_range(0, 7));
            bus.in_rs2     = AW'($urandom_range(0, 7));
            bus.in_use_rs1 = 1'($urandom_range(0, 1));
            bus.in_use_rs2 = 1'($urandom_range(0, 1));
            bus.in_rd      = AW'($urandom_range(0, 7));
            bus.in_rd_wr   = 1'($urandom_range(0, 1));
            bus.wb_en      = 1'($urandom_range(0, 1));
            bus.wb_addr    = AW'($urandom_range(0, 7));
            bus.wb_data    = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
